// File: rtl/game_tick_sched.sv
// game_tick_sched
// ---------------
// Programmable game-speed tick scheduler. A single prescaler counter on the
// board clock issues one-cycle `tick` enables that pace the game logic, so
// all game logic stays on `clk` instead of a derived clock. The tick period
// starts at BASE_DIV and shrinks by STEP_DIV on every level-up, down to
// MIN_DIV. The game FSM can start, pause and stop the timebase.
//
// Optional feature macro: GAME_SPEEDUP_EN
//   defined   : level progression (tick counting, level-up, period step-down)
//   undefined : level and level_up stay 0, cur_div stays BASE_DIV
//
// Ports:
//   clk      in   board clock
//   reset    in   synchronous, active-high reset
//   start    in   start request, honoured in IDLE only
//   pause    in   level-sensitive hold, honoured in RUN/PAUSE
//   stop     in   abort to IDLE, honoured in any state (beats pause/start)
//   tick     out  one-cycle game enable pulse
//   level_up out  one-cycle pulse coincident with the tick that levels up
//   level    out  current level (saturating)
//   running  out  high in RUN
//   paused   out  high in PAUSE
//   cur_div  out  active tick period in clk cycles

module game_tick_sched #(
    parameter int unsigned BASE_DIV        = 32'd10000000,
    parameter int unsigned STEP_DIV        = 32'd1000000,
    parameter int unsigned MIN_DIV         = 32'd2000000,
    parameter int unsigned TICKS_PER_LEVEL = 32'd50,
    parameter int unsigned LVL_W           = 32'd4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             tick,
    output logic             level_up,
    output logic [LVL_W-1:0] level,
    output logic             running,
    output logic             paused,
    output logic [31:0]      cur_div
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [31:0] BASE_DIV_C = 32'(BASE_DIV);

    state_e           state_r;
    state_e           next_state_s;
    logic [31:0]      cnt_r;
    logic             tick_r;
    logic             running_r;
    logic             paused_r;
    logic [31:0]      cur_div_r;
    logic [LVL_W-1:0] level_r;
    logic             level_up_r;
    logic             count_en_s;
    logic             terminal_s;
    logic             tick_s;

    // Next-state logic: stop overrides everything, pause only matters once running.
    always_comb begin
        next_state_s = state_r;
        if (stop) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (pause) begin
                        next_state_s = ST_PAUSE;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Counting enable and terminal-count decode.
    // The counter also advances on the PAUSE->RUN release cycle, so a pause
    // lengthens the period by exactly the number of cycles pause was high,
    // and a terminal count frozen by pause fires on that release cycle.
    always_comb begin
        count_en_s = 1'b0;
        terminal_s = 1'b0;
        tick_s     = 1'b0;
        count_en_s = (state_r != ST_IDLE) && !pause && !stop;
        terminal_s = (cnt_r == (cur_div_r - 32'd1));
        tick_s     = count_en_s && terminal_s;
    end

    // State register, prescaler counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 32'd0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            paused_r  <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            running_r <= (next_state_s == ST_RUN);
            paused_r  <= (next_state_s == ST_PAUSE);
            tick_r    <= tick_s;
            if (stop || (state_r == ST_IDLE)) begin
                cnt_r <= 32'd0;
            end else if (tick_s) begin
                cnt_r <= 32'd0;
            end else if (count_en_s) begin
                cnt_r <= cnt_r + 32'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef GAME_SPEEDUP_EN
    localparam int unsigned TCNT_W = (TICKS_PER_LEVEL > 32'd1) ? $clog2(TICKS_PER_LEVEL) : 32'd1;
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TICKS_PER_LEVEL - 32'd1);
    localparam logic [31:0]       MIN_DIV_C  = 32'(MIN_DIV);
    localparam logic [31:0]       STEP_DIV_C = 32'(STEP_DIV);
    // 33 bits so MIN_DIV+STEP_DIV cannot wrap before the compare.
    localparam logic [32:0]       FLOOR_KNEE = 33'(MIN_DIV) + 33'(STEP_DIV);
    localparam logic [LVL_W-1:0]  LVL_MAX    = {LVL_W{1'b1}};

    logic [TCNT_W-1:0] tcnt_r;
    logic              lvl_step_s;

    // Level-up happens on the tick that completes a group of ticks.
    always_comb begin
        lvl_step_s = 1'b0;
        lvl_step_s = tick_s && (tcnt_r == TCNT_LAST);
    end

    // Tick counter, level and period step-down.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_r     <= '0;
            level_r    <= '0;
            level_up_r <= 1'b0;
            cur_div_r  <= BASE_DIV_C;
        end else if (stop || (state_r == ST_IDLE)) begin
            tcnt_r     <= '0;
            level_r    <= '0;
            level_up_r <= 1'b0;
            cur_div_r  <= BASE_DIV_C;
        end else begin
            level_up_r <= lvl_step_s;
            if (lvl_step_s) begin
                tcnt_r <= '0;
                if (level_r != LVL_MAX) begin
                    level_r <= level_r + LVL_W'(1);
                end
                // Period keeps stepping toward the floor after level saturates.
                if ({1'b0, cur_div_r} < FLOOR_KNEE) begin
                    cur_div_r <= MIN_DIV_C;
                end else begin
                    cur_div_r <= cur_div_r - STEP_DIV_C;
                end
            end else if (tick_s) begin
                tcnt_r <= tcnt_r + TCNT_W'(1);
            end
        end
    end
`else
    // Progression parameters are meaningless without the speed-up feature.
    logic [31:0] unused_cfg_s;
    assign unused_cfg_s = STEP_DIV ^ MIN_DIV ^ TICKS_PER_LEVEL;

    // Fixed-speed build: level stays 0 and the period stays BASE_DIV.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r    <= '0;
            level_up_r <= 1'b0;
            cur_div_r  <= BASE_DIV_C;
        end else begin
            level_r    <= '0;
            level_up_r <= 1'b0;
            cur_div_r  <= BASE_DIV_C;
        end
    end
`endif

    assign tick     = tick_r;
    assign level_up = level_up_r;
    assign level    = level_r;
    assign running  = running_r;
    assign paused   = paused_r;
    assign cur_div  = cur_div_r;

endmodule

// File: tb/tb_game_tick_sched.sv
// Bench for game_tick_sched with BASE_DIV=10, STEP_DIV=3, MIN_DIV=4,
// TICKS_PER_LEVEL=2, LVL_W=2. Expected ticks (cycle, level, level_up,
// cur_div) are predicted by a small model when stimulus is planned, pushed
// to a queue, and popped by a negedge monitor whenever tick is seen or an
// expected tick is overdue. Expectations follow GAME_SPEEDUP_EN.

module tb_game_tick_sched;

    localparam int unsigned BASE = 10;
    localparam int unsigned STEP = 3;
    localparam int unsigned MIN  = 4;
    localparam int unsigned TPL  = 2;
`ifdef GAME_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] lvl;
        logic        lu;
        logic [31:0] div;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        pause;
    logic        stop;
    logic        tick;
    logic        level_up;
    logic [1:0]  level;
    logic        running;
    logic        paused;
    logic [31:0] cur_div;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // Model state
    int m_last;
    int m_div;
    int m_lvl;
    int m_tc;

    game_tick_sched #(
        .BASE_DIV       (BASE),
        .STEP_DIV       (STEP),
        .MIN_DIV        (MIN),
        .TICKS_PER_LEVEL(TPL),
        .LVL_W          (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pause   (pause),
        .stop    (stop),
        .tick    (tick),
        .level_up(level_up),
        .level   (level),
        .running (running),
        .paused  (paused),
        .cur_div (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic model_restart(input int entry);
        m_last = entry;
        m_div  = BASE;
        m_lvl  = 0;
        m_tc   = 0;
    endtask

    // Predict the next tick, `extra` cycles late because of pause.
    task automatic push_tick(input int extra);
        exp_t e;
        logic lu;
        lu     = 1'b0;
        m_last = m_last + m_div + extra;
        if (SPEEDUP) begin
            if (m_tc == TPL - 1) begin
                lu   = 1'b1;
                m_tc = 0;
                if (m_lvl < 3) m_lvl = m_lvl + 1;
                if (m_div < MIN + STEP) m_div = MIN;
                else m_div = m_div - STEP;
            end else begin
                m_tc = m_tc + 1;
            end
        end
        e.cyc = m_last;
        e.lvl = 32'(m_lvl);
        e.lu  = lu;
        e.div = 32'(m_div);
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (tick === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_tick", 32'(tick), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("tick_level", 32'(level), mon_e.lvl);
                    chk("tick_level_up", 32'(level_up), 32'(mon_e.lu));
                    chk("tick_cur_div", cur_div, mon_e.div);
                end
            end else begin
                chk("level_up_without_tick", 32'(level_up), 32'd0);
                if (sb_q.size() != 0) begin
                    if (cyc >= sb_q[0].cyc) begin
                        mon_e = sb_q.pop_front();
                        chk("missed_tick", 32'(tick), 32'd1);
                    end
                end
            end
        end
    end

    // Hard time limit.
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int t1;
        int t2;
        int d;
        reset = 1'b1;
        start = 1'b1;
        pause = 1'b0;
        stop  = 1'b0;

        // Reset held 3 cycles with start asserted.
        step(3);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_level_up", 32'(level_up), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        chk("rst_cur_div", cur_div, 32'd10);
        reset = 1'b0;
        start = 1'b0;
        step(1);
        chk("idle_after_rst_running", 32'(running), 32'd0);

        // Start and free-run 10 ticks.
        start = 1'b1;
        step(1);
        start = 1'b0;
        model_restart(cyc);
        chk("start_running", 32'(running), 32'd1);
        chk("start_paused", 32'(paused), 32'd0);
        for (int i = 0; i < 10; i++) push_tick(0);
        goto(m_last + 1);

        // Stop exactly on a terminal cycle.
        goto(m_last + m_div - 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_tick", 32'(tick), 32'd0);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_level", 32'(level), 32'd0);
        chk("stop_cur_div", cur_div, 32'd10);
        step(2);
        chk("stop_still_idle", 32'(running), 32'd0);

        // Fresh start, then pause for 5 cycles at cnt=6 in the second period.
        start = 1'b1;
        step(1);
        start = 1'b0;
        model_restart(cyc);
        push_tick(0);
        t1 = m_last;
        push_tick(5);
        t2 = m_last;
        d  = m_div;
        goto(t1 + 6);
        pause = 1'b1;
        goto(t1 + 8);
        chk("pause_paused", 32'(paused), 32'd1);
        chk("pause_running", 32'(running), 32'd0);
        chk("pause_tick", 32'(tick), 32'd0);
        goto(t1 + 11);
        pause = 1'b0;
        goto(t2 + 1);

        // Pause exactly on the terminal cycle for 3 cycles.
        goto(t2 + d - 1);
        pause = 1'b1;
        step(1);
        chk("term_pause_tick", 32'(tick), 32'd0);
        chk("term_pause_paused", 32'(paused), 32'd1);
        goto(t2 + d + 2);
        pause = 1'b0;
        push_tick(3);
        goto(m_last + 1);
        chk("resume_running", 32'(running), 32'd1);

        step(3);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
